// File: rtl/iagc_pkg.sv
// Shared IAGC loop definitions: status encodings and default datapath widths.
// Imported by every block that sits in the gain-control path.
package iagc_pkg;

  localparam int IAGC_STATUS_WIDTH = 4;
  localparam int DEF_SAMPLER_DATA_SIZE = 16;
  localparam int DEF_AMPLITUDE_COUNT_SIZE = 16;

  typedef enum logic [IAGC_STATUS_WIDTH-1:0] {
    IAGC_IDLE    = 4'd0,
    IAGC_ACQUIRE = 4'd1,
    IAGC_DETECT  = 4'd2
  } iagc_status_e;

endpackage

// File: rtl/peak_tracker.sv
// Saturating absolute value of one signed channel plus its running-max register.
// o_window_max already folds in the current sample so the closing edge needs no bubble.
module peak_tracker
  import iagc_pkg::*;
#(
  parameter int W = DEF_SAMPLER_DATA_SIZE
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_accept,
  input  logic         i_close,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_window_max
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0] w_neg;
  logic [W-1:0] w_abs;
  logic [W-1:0] r_peak;

  // Negating the most-negative code yields itself; clamp it instead.
  assign w_neg = ~i_data + 1'b1;
  assign w_abs = !i_data[W-1] ? i_data :
                 (w_neg[W-1] ? MAX_POS : w_neg);

  assign o_window_max = (w_abs > r_peak) ? w_abs : r_peak;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_peak <= '0;
    end else if (i_clear || (i_accept && i_close)) begin
      r_peak <= '0;
    end else if (i_accept) begin
      r_peak <= o_window_max;
    end
  end

endmodule

// File: rtl/amplitude_detector.sv
// Per-window peak |reference| and |error| detector for the IAGC loop.
// Both channels share one sample counter and publish together.
module amplitude_detector
  import iagc_pkg::*;
#(
  parameter int IAGC_STATUS_SIZE = IAGC_STATUS_WIDTH,
  parameter int SAMPLER_DATA_SIZE = DEF_SAMPLER_DATA_SIZE,
  parameter int AMPLITUDE_COUNT_SIZE = DEF_AMPLITUDE_COUNT_SIZE,
  parameter logic [IAGC_STATUS_SIZE-1:0] STATUS_DETECT = IAGC_DETECT
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_sample,
  input  logic [IAGC_STATUS_SIZE-1:0]     i_iagc_status,
  input  logic [SAMPLER_DATA_SIZE-1:0]    i_reference,
  input  logic [SAMPLER_DATA_SIZE-1:0]    i_error,
  input  logic [AMPLITUDE_COUNT_SIZE-1:0] i_amplitude_count,
  output logic [SAMPLER_DATA_SIZE-1:0]    o_reference_amplitude,
  output logic [SAMPLER_DATA_SIZE-1:0]    o_error_amplitude,
  output logic                            o_amplitude_valid
);

  localparam int CW = AMPLITUDE_COUNT_SIZE;
  localparam int DW = SAMPLER_DATA_SIZE;

  logic          w_detect;
  logic          w_accept;
  logic          w_close;
  logic [CW-1:0] w_new_len;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_count_inc;
  logic [DW-1:0] w_ref_max;
  logic [DW-1:0] w_err_max;

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_len;
  logic [DW-1:0] r_ref_amp;
  logic [DW-1:0] r_err_amp;
  logic          r_valid;

  assign w_detect = (i_iagc_status == STATUS_DETECT);
  assign w_accept = w_detect && i_sample;

  // The first sample of a window sees the live length, later ones the latched one.
  assign w_new_len = (i_amplitude_count == '0) ? CW'(1) : i_amplitude_count;
  assign w_len = (r_count == '0) ? w_new_len : r_len;
  assign w_count_inc = r_count + 1'b1;
  assign w_close = w_accept && (w_count_inc == w_len);

  peak_tracker #(.W(DW)) u_ref_peak (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (!w_detect),
    .i_accept     (w_accept),
    .i_close      (w_close),
    .i_data       (i_reference),
    .o_window_max (w_ref_max)
  );

  peak_tracker #(.W(DW)) u_err_peak (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (!w_detect),
    .i_accept     (w_accept),
    .i_close      (w_close),
    .i_data       (i_error),
    .o_window_max (w_err_max)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count   <= '0;
      r_len     <= '0;
      r_ref_amp <= '0;
      r_err_amp <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_close;
      if (!w_detect) begin
        r_count <= '0;
      end else if (w_accept) begin
        if (r_count == '0) begin
          r_len <= w_new_len;
        end
        r_count <= w_close ? '0 : w_count_inc;
      end
      if (w_close) begin
        r_ref_amp <= w_ref_max;
        r_err_amp <= w_err_max;
      end
    end
  end

  assign o_reference_amplitude = r_ref_amp;
  assign o_error_amplitude     = r_err_amp;
  assign o_amplitude_valid     = r_valid;

endmodule

// File: tb/tb_amplitude_detector.sv
// Scoreboard bench for amplitude_detector: a window-list reference model
// predicts each published pair; a negedge monitor pops and compares.
module tb_amplitude_detector;
  import iagc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smp = 1'b0;
  logic [3:0]  st = 4'd0;
  logic [15:0] rf = '0;
  logic [15:0] er = '0;
  logic [15:0] cnt = '0;
  logic [15:0] o_ref;
  logic [15:0] o_err;
  logic        o_val;

  always #5 clk = ~clk;

  amplitude_detector dut (
    .i_clock               (clk),
    .i_reset               (rst),
    .i_sample              (smp),
    .i_iagc_status         (st),
    .i_reference           (rf),
    .i_error               (er),
    .i_amplitude_count     (cnt),
    .o_reference_amplitude (o_ref),
    .o_error_amplitude     (o_err),
    .o_amplitude_valid     (o_val)
  );

  typedef struct {
    int r;
    int e;
  } exp_t;

  exp_t sbq[$];
  int   win_r[$];
  int   win_e[$];
  int   cur_len = 0;
  int   held_r = 0;
  int   held_e = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   run = 1'b1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int absat(logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int maxq(int q[$]);
    int m;
    m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // Model: a window is the list of |x| values since it opened.
  task automatic step(bit s, int stv, int r, int e, int c);
    exp_t x;
    smp = s;
    st  = stv[3:0];
    rf  = r[15:0];
    er  = e[15:0];
    cnt = c[15:0];
    if (stv != 2) begin
      win_r.delete();
      win_e.delete();
    end else if (s) begin
      if (win_r.size() == 0) cur_len = (c[15:0] == 16'd0) ? 1 : int'(c[15:0]);
      win_r.push_back(absat(r[15:0]));
      win_e.push_back(absat(e[15:0]));
      if (win_r.size() == cur_len) begin
        x.r = maxq(win_r);
        x.e = maxq(win_e);
        sbq.push_back(x);
        win_r.delete();
        win_e.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (run && !rst) begin
      if (o_val) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          x = sbq.pop_front();
          held_r = x.r;
          held_e = x.e;
          chk("ref_amp", int'(o_ref), held_r);
          chk("err_amp", int'(o_err), held_e);
        end
      end else begin
        chk("ref_hold", int'(o_ref), held_r);
        chk("err_hold", int'(o_err), held_e);
      end
    end
  end

  task automatic async_reset();
    step(0, 2, 0, 0, 4);
    #2;
    rst = 1'b1;
    win_r.delete();
    win_e.delete();
    held_r = 0;
    held_e = 0;
    #1;
    chk("rst_ref_now", int'(o_ref), 0);
    chk("rst_err_now", int'(o_err), 0);
    chk("rst_val_now", int'(o_val), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ref", int'(o_ref), 0);
    chk("reset_err", int'(o_err), 0);
    chk("reset_val", int'(o_val), 0);
    rst = 1'b0;

    // Idle status: samples ignored, nothing published.
    for (int i = 0; i < 20; i++)
      step(bit'($urandom % 2), 0, int'($urandom), int'($urandom), 4);

    // Window of 4, then a clean second window.
    step(1, 2, 3, 1, 4);
    step(1, 2, -7, 1, 4);
    step(1, 2, 5, -2, 4);
    step(1, 2, 2, 0, 4);
    step(0, 2, 0, 0, 4);
    step(1, 2, 1, 1, 4);
    step(1, 2, -1, 0, 4);
    step(1, 2, 0, 1, 4);
    step(1, 2, 1, -1, 4);

    // Most-negative saturates; window of one.
    step(1, 2, 0, -32768, 1);
    step(1, 2, 0, 100, 1);
    step(0, 2, 0, 0, 1);

    // Interrupted window is discarded.
    for (int i = 0; i < 5; i++) step(1, 2, 50, -60, 8);
    for (int i = 0; i < 3; i++) step(1, 1, 70, 70, 8);
    for (int i = 0; i < 8; i++) step(1, 2, (i % 2) ? 9 : -9, (i % 2) ? -9 : 9, 8);

    // Async reset mid-window, then a full fresh window.
    for (int i = 0; i < 3; i++) step(1, 2, 40, 40, 4);
    async_reset();
    for (int i = 0; i < 3; i++) step(1, 2, 11 + i, -20, 4);
    step(0, 2, 0, 0, 4);
    step(1, 2, 5, 5, 4);

    // Zero length acts as one; mid-window length change waits.
    for (int i = 0; i < 3; i++) step(1, 2, 100 * i, -3 * i, 0);
    step(1, 2, 4, 4, 4);
    step(1, 2, 6, 6, 4);
    step(1, 2, 8, 8, 2);
    step(1, 2, 1, 1, 2);
    step(1, 2, 2, -30, 2);
    step(1, 2, -3, 3, 2);
    step(1, 2, 7, 7, 2);
    step(1, 2, 7, 7, 2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sv;
      sv = ($urandom % 5 < 4) ? 2 : int'($urandom % 2);
      step(bit'($urandom % 4 != 0), sv, int'($urandom),
           int'($urandom), int'($urandom % 7));
    end

    repeat (3) step(0, 0, 0, 0, 0);
    run = 1'b0;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
